// File: rtl/dii_length_framer.sv
// dii_length_framer
//
// Takes packets from a full-packet DII buffer and emits them as a 16-bit
// length-prefixed word stream. Each packet becomes one header word holding
// the flit count, followed by the payload flits in order. A disagreement
// between the flit `last` marker and the announced length sets a sticky
// error flag.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   packet_size    flit count of the head packet (0 = no complete packet)
//   flit_in        DII flit {valid, last, data[15:0]}
//   flit_in_ready  consume the head flit (combinational)
//   out_data       framed word
//   out_valid      out_data holds a word
//   out_ready      sink accepts the word
//   frame_err      sticky framing-mismatch flag
//   pkt_count      completed packets, wraps modulo 2^16
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// A flit transfers on a rising edge where flit_in.valid && flit_in_ready.
// out_data is held stable while out_valid is high and out_ready is low, and
// no flit is consumed in that cycle.

package dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module dii_length_framer
  import dii_pkg::*;
#(
  parameter int BUF_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(BUF_SIZE):0] packet_size,
  input  dii_flit                   flit_in,
  output logic                      flit_in_ready,
  output logic [15:0]               out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_err,
  output logic [15:0]               pkt_count
);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  state_t      state;
  logic [15:0] remaining;
  logic [15:0] size_word;
  logic        slot_free;
  logic        header_load;
  logic        flit_fire;
  logic        last_of_count;

  // packet_size never exceeds the buffer depth, which fits in 16 bits.
  assign size_word     = 16'(packet_size);
  assign slot_free     = !out_valid || out_ready;
  assign flit_in_ready = (state == PAYLOAD) && slot_free;
  assign flit_fire     = flit_in.valid && flit_in_ready;
  assign header_load   = (state == IDLE) && flit_in.valid
                         && (packet_size != '0) && slot_free;
  assign last_of_count = (remaining == 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= 16'd0;
      out_data  <= 16'd0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (header_load) begin
            out_data  <= size_word;
            out_valid <= 1'b1;
            remaining <= size_word;
            state     <= PAYLOAD;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        PAYLOAD: begin
          if (flit_fire) begin
            out_data  <= flit_in.data;
            out_valid <= 1'b1;
            remaining <= remaining - 16'd1;
            // Either marker ends the packet; disagreement is only flagged.
            if (flit_in.last != last_of_count) begin
              frame_err <= 1'b1;
            end
            if (flit_in.last || last_of_count) begin
              state     <= IDLE;
              pkt_count <= pkt_count + 16'd1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
